// File: rtl/sma_conf_loader_pkg.sv
// Shared constants, command codes, header field helpers and FSM states
// for the SMA configuration loader.
package sma_conf_loader_pkg;

  localparam int ROW_NUM = 8;
  localparam int COL_NUM = 12;
  localparam int ALU_W   = 5;
  localparam int SEL_W   = 4;
  localparam int SE_W    = 2;
  localparam int WORD_W  = 32;

  localparam int PAYLOAD_W = COL_NUM * (ALU_W + 2 * SEL_W + SE_W);
  localparam int WPR       = (PAYLOAD_W + WORD_W - 1) / WORD_W;
  localparam int CNT_W     = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int ROW_W     = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;

  // Field offsets inside one row payload, LSB first.
  localparam int ALU_LSB  = 0;
  localparam int SELA_LSB = ALU_LSB + COL_NUM * ALU_W;
  localparam int SELB_LSB = SELA_LSB + COL_NUM * SEL_W;
  localparam int SE_LSB   = SELB_LSB + COL_NUM * SEL_W;

  localparam int CMD_MSB = 31;
  localparam int CMD_LSB = 28;
  localparam int ROW_MSB = 7;
  localparam int ROW_LSB = 0;

  localparam logic [3:0] CMD_LOAD_ROW = 4'h1;
  localparam logic [3:0] CMD_COMMIT   = 4'h2;
  localparam logic [3:0] CMD_CLR_ERR  = 4'h3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_COMMIT
  } state_e;

  function automatic logic [3:0] hdr_cmd(input logic [WORD_W-1:0] w);
    return w[CMD_MSB:CMD_LSB];
  endfunction

  function automatic logic [7:0] hdr_row(input logic [WORD_W-1:0] w);
    return w[ROW_MSB:ROW_LSB];
  endfunction

endpackage

// File: rtl/sma_conf_row_buf.sv
// One PE row's configuration: a word-addressed shadow register and the
// active copy that the array sees, refreshed from shadow on commit.
module sma_conf_row_buf
  import sma_conf_loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [CNT_W-1:0]         wr_idx,
  input  logic [WORD_W-1:0]        wr_data,
  input  logic                     commit,
  output logic [COL_NUM*ALU_W-1:0] alu,
  output logic [COL_NUM*SEL_W-1:0] sel_a,
  output logic [COL_NUM*SEL_W-1:0] sel_b,
  output logic [COL_NUM*SE_W-1:0]  se
);

  logic [PAYLOAD_W-1:0] shadow_q;
  logic [PAYLOAD_W-1:0] active_q;

  // Only payload bits are stored; the padding above the last word is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (wr_en) begin
        for (int i = 0; i < PAYLOAD_W; i++) begin
          if (CNT_W'(i / WORD_W) == wr_idx) shadow_q[i] <= wr_data[i % WORD_W];
        end
      end
      if (commit) active_q <= shadow_q;
    end
  end

  assign alu   = active_q[ALU_LSB  +: COL_NUM*ALU_W];
  assign sel_a = active_q[SELA_LSB +: COL_NUM*SEL_W];
  assign sel_b = active_q[SELB_LSB +: COL_NUM*SEL_W];
  assign se    = active_q[SE_LSB   +: COL_NUM*SE_W];

endmodule

// File: rtl/sma_conf_loader.sv
// Stream-fed configuration loader for the SMA PE rows: parses headers,
// fills per-row shadow buffers and commits all rows at once.
module sma_conf_loader
  import sma_conf_loader_pkg::*;
(
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             IN_VALID,
  output logic                             IN_READY,
  input  logic [WORD_W-1:0]                IN_DATA,
  output logic [ROW_NUM*COL_NUM*ALU_W-1:0] CONF_ALU_ALL,
  output logic [ROW_NUM*COL_NUM*SEL_W-1:0] CONF_SEL_A_ALL,
  output logic [ROW_NUM*COL_NUM*SEL_W-1:0] CONF_SEL_B_ALL,
  output logic [ROW_NUM*COL_NUM*SE_W-1:0]  CONF_SE_ALL,
  output logic                             CONF_UPDATE,
  output logic                             BUSY,
  output logic                             ERR
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [ROW_W-1:0] row_q;
  logic             accept;
  logic             last_word;
  logic             start_load;
  logic             set_err;
  logic             clr_err;
  logic             commit;

  assign IN_READY  = (state_q != S_COMMIT);
  assign BUSY      = (state_q != S_IDLE);
  assign accept    = IN_VALID & IN_READY;
  assign last_word = (cnt_q == CNT_W'(WPR - 1));
  assign commit    = (state_q == S_COMMIT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    start_load = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (hdr_cmd(IN_DATA))
            CMD_LOAD_ROW: begin
              if (hdr_row(IN_DATA) < 8'(ROW_NUM)) begin
                state_d    = S_LOAD;
                start_load = 1'b1;
              end else begin
                state_d = S_DRAIN;
                set_err = 1'b1;
              end
            end
            CMD_COMMIT:  state_d = S_COMMIT;
            CMD_CLR_ERR: clr_err = 1'b1;
            default:     set_err = 1'b1;
          endcase
        end
      end
      S_LOAD, S_DRAIN: begin
        if (accept && last_word) state_d = S_IDLE;
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Payload word counter shared by LOAD and DRAIN; it only moves on accepted words.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q       <= '0;
      row_q       <= '0;
      ERR         <= 1'b0;
      CONF_UPDATE <= 1'b0;
    end else begin
      if ((state_q == S_LOAD || state_q == S_DRAIN) && accept)
        cnt_q <= last_word ? '0 : cnt_q + 1'b1;
      if (start_load) row_q <= IN_DATA[ROW_W-1:0];
      if (set_err)      ERR <= 1'b1;
      else if (clr_err) ERR <= 1'b0;
      CONF_UPDATE <= commit;
    end
  end

  for (genvar r = 0; r < ROW_NUM; r++) begin : g_row
    logic wr_en;
    assign wr_en = (state_q == S_LOAD) && accept && (row_q == ROW_W'(r));

    sma_conf_row_buf u_buf (
      .clk     (CLK),
      .rst     (RST),
      .wr_en   (wr_en),
      .wr_idx  (cnt_q),
      .wr_data (IN_DATA),
      .commit  (commit),
      .alu     (CONF_ALU_ALL  [r*COL_NUM*ALU_W +: COL_NUM*ALU_W]),
      .sel_a   (CONF_SEL_A_ALL[r*COL_NUM*SEL_W +: COL_NUM*SEL_W]),
      .sel_b   (CONF_SEL_B_ALL[r*COL_NUM*SEL_W +: COL_NUM*SEL_W]),
      .se      (CONF_SE_ALL   [r*COL_NUM*SE_W  +: COL_NUM*SE_W])
    );
  end

endmodule

// File: tb/tb_sma_conf_loader.sv
// Self-checking bench for sma_conf_loader: a stream-level model compared every
// cycle, plus literal expectations for the directed scenarios.
module tb_sma_conf_loader;
  import sma_conf_loader_pkg::*;

  localparam int ALU_ROW = COL_NUM * ALU_W;
  localparam int SEL_ROW = COL_NUM * SEL_W;
  localparam int SE_ROW  = COL_NUM * SE_W;

  logic                             CLK = 1'b0;
  logic                             RST;
  logic                             IN_VALID;
  logic                             IN_READY;
  logic [WORD_W-1:0]                IN_DATA;
  logic [ROW_NUM*COL_NUM*ALU_W-1:0] CONF_ALU_ALL;
  logic [ROW_NUM*COL_NUM*SEL_W-1:0] CONF_SEL_A_ALL;
  logic [ROW_NUM*COL_NUM*SEL_W-1:0] CONF_SEL_B_ALL;
  logic [ROW_NUM*COL_NUM*SE_W-1:0]  CONF_SE_ALL;
  logic                             CONF_UPDATE;
  logic                             BUSY;
  logic                             ERR;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  sma_conf_loader dut (
    .CLK            (CLK),
    .RST            (RST),
    .IN_VALID       (IN_VALID),
    .IN_READY       (IN_READY),
    .IN_DATA        (IN_DATA),
    .CONF_ALU_ALL   (CONF_ALU_ALL),
    .CONF_SEL_A_ALL (CONF_SEL_A_ALL),
    .CONF_SEL_B_ALL (CONF_SEL_B_ALL),
    .CONF_SE_ALL    (CONF_SE_ALL),
    .CONF_UPDATE    (CONF_UPDATE),
    .BUSY           (BUSY),
    .ERR            (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [511:0] actual,
                             input logic [511:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Stream model: interprets accepted words as headers/payloads per row.
  logic [PAYLOAD_W-1:0] shadow_m [ROW_NUM];
  logic [PAYLOAD_W-1:0] active_m [ROW_NUM];
  int  words_left = 0;
  int  word_k     = 0;
  int  cur_row    = 0;
  bit  commit_now = 1'b0;
  bit  err_m      = 1'b0;
  bit  upd_m      = 1'b0;

  always @(posedge CLK or posedge RST) begin
    logic [WPR*WORD_W-1:0] tmp;
    int row;
    if (RST) begin
      for (int r = 0; r < ROW_NUM; r++) begin
        shadow_m[r] = '0;
        active_m[r] = '0;
      end
      words_left = 0;
      word_k     = 0;
      commit_now = 1'b0;
      err_m      = 1'b0;
      upd_m      = 1'b0;
    end else begin
      upd_m = 1'b0;
      if (commit_now) begin
        for (int r = 0; r < ROW_NUM; r++) active_m[r] = shadow_m[r];
        upd_m      = 1'b1;
        commit_now = 1'b0;
      end else if (IN_VALID === 1'b1) begin
        if (words_left > 0) begin
          if (cur_row >= 0) begin
            tmp = (WPR*WORD_W)'(shadow_m[cur_row]);
            tmp[word_k*WORD_W +: WORD_W] = IN_DATA;
            shadow_m[cur_row] = tmp[PAYLOAD_W-1:0];
          end
          word_k++;
          words_left--;
        end else begin
          row = int'(IN_DATA[7:0]);
          case (IN_DATA[31:28])
            4'h1: begin
              cur_row    = (row < ROW_NUM) ? row : -1;
              if (row >= ROW_NUM) err_m = 1'b1;
              words_left = WPR;
              word_k     = 0;
            end
            4'h2: commit_now = 1'b1;
            4'h3: err_m = 1'b0;
            default: err_m = 1'b1;
          endcase
        end
      end
    end
  end

  always @(negedge CLK) begin
    logic [ROW_NUM*ALU_ROW-1:0] exp_alu;
    logic [ROW_NUM*SEL_ROW-1:0] exp_sa;
    logic [ROW_NUM*SEL_ROW-1:0] exp_sb;
    logic [ROW_NUM*SE_ROW-1:0]  exp_se;
    if (check_en) begin
      for (int r = 0; r < ROW_NUM; r++) begin
        exp_alu[r*ALU_ROW +: ALU_ROW] = active_m[r][ALU_LSB  +: ALU_ROW];
        exp_sa [r*SEL_ROW +: SEL_ROW] = active_m[r][SELA_LSB +: SEL_ROW];
        exp_sb [r*SEL_ROW +: SEL_ROW] = active_m[r][SELB_LSB +: SEL_ROW];
        exp_se [r*SE_ROW  +: SE_ROW]  = active_m[r][SE_LSB   +: SE_ROW];
      end
      checkOutput("m_ready",  512'(IN_READY),       512'(!commit_now));
      checkOutput("m_busy",   512'(BUSY),           512'(words_left > 0 || commit_now));
      checkOutput("m_err",    512'(ERR),            512'(err_m));
      checkOutput("m_update", 512'(CONF_UPDATE),    512'(upd_m));
      checkOutput("m_alu",    512'(CONF_ALU_ALL),   512'(exp_alu));
      checkOutput("m_sel_a",  512'(CONF_SEL_A_ALL), 512'(exp_sa));
      checkOutput("m_sel_b",  512'(CONF_SEL_B_ALL), 512'(exp_sb));
      checkOutput("m_se",     512'(CONF_SE_ALL),    512'(exp_se));
    end
  end

  task automatic applyStimulus(input logic [WORD_W-1:0] w);
    int guard = 0;
    @(negedge CLK);
    while (IN_READY !== 1'b1 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 20) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout: got IN_READY=%b expected 1", IN_READY);
    end
    IN_VALID = 1'b1;
    IN_DATA  = w;
    @(posedge CLK);
  endtask

  task automatic endBurst();
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  function automatic logic [WORD_W-1:0] load_hdr(input int row);
    return {CMD_LOAD_ROW, 20'h0, 8'(row)};
  endfunction

  task automatic loadRow(input int row, input logic [WORD_W-1:0] w0, input int step);
    applyStimulus(load_hdr(row));
    for (int i = 0; i < WPR; i++) applyStimulus(w0 + WORD_W'(i * step));
  endtask

  initial begin : wdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    RST      = 1'b1;
    IN_VALID = 1'b0;
    IN_DATA  = '0;
    repeat (2) @(negedge CLK);
    check_en = 1'b1;
    checkOutput("rst_ready",  512'(IN_READY),     512'(1'b1));
    checkOutput("rst_busy",   512'(BUSY),         512'(1'b0));
    checkOutput("rst_alu",    512'(CONF_ALU_ALL), 512'(0));
    #2 RST = 1'b0;

    // 1: load row 2 with 1..6, commit, watch the one-cycle update pulse
    loadRow(2, 32'h1, 1);
    applyStimulus({CMD_COMMIT, 28'h0});
    endBurst();
    checkOutput("t1_ready_commit", 512'(IN_READY),    512'(1'b0));
    checkOutput("t1_busy_commit",  512'(BUSY),        512'(1'b1));
    checkOutput("t1_upd_early",    512'(CONF_UPDATE), 512'(1'b0));
    @(negedge CLK);
    checkOutput("t1_upd_pulse",    512'(CONF_UPDATE), 512'(1'b1));
    checkOutput("t1_alu_r2c0",     512'(CONF_ALU_ALL[2*ALU_ROW +: ALU_W]), 512'(5'h01));
    checkOutput("t1_sela_r2c1",    512'(CONF_SEL_A_ALL[2*SEL_ROW + SEL_W +: SEL_W]), 512'(4'h3));
    checkOutput("t1_alu_r0",       512'(CONF_ALU_ALL[0 +: ALU_ROW]), 512'(0));
    @(negedge CLK);
    checkOutput("t1_upd_end",      512'(CONF_UPDATE), 512'(1'b0));

    // 2: load row 0 without commit
    loadRow(0, 32'hDEAD_BEEF, 3);
    endBurst();
    repeat (3) @(negedge CLK);
    checkOutput("t2_alu_r0", 512'(CONF_ALU_ALL[0 +: ALU_ROW]), 512'(0));
    checkOutput("t2_upd",    512'(CONF_UPDATE), 512'(1'b0));

    // 3: bad row drains, clear, then unknown command
    loadRow(9, 32'hFFFF_FFFF, 0);
    endBurst();
    checkOutput("t3_err_set",   512'(ERR),      512'(1'b1));
    checkOutput("t3_ready",     512'(IN_READY), 512'(1'b1));
    checkOutput("t3_idle",      512'(BUSY),     512'(1'b0));
    applyStimulus({CMD_CLR_ERR, 28'h0});
    endBurst();
    checkOutput("t3_err_clr",   512'(ERR), 512'(1'b0));
    applyStimulus(32'h7000_0000);
    endBurst();
    checkOutput("t3_err_badcmd", 512'(ERR), 512'(1'b1));

    // 4: stalled load of row 7, valid toggling every cycle
    applyStimulus(load_hdr(7));
    for (int i = 0; i < WPR; i++) begin
      endBurst();
      checkOutput("t4_busy_stall", 512'(BUSY), 512'(1'b1));
      applyStimulus(32'h1234_5678 + WORD_W'(i * 32'h0101_0101));
    end
    applyStimulus({CMD_COMMIT, 28'h0});
    endBurst();
    repeat (2) @(negedge CLK);
    checkOutput("t4_alu_r7c0", 512'(CONF_ALU_ALL[7*ALU_ROW +: ALU_W]), 512'(5'h18));

    // 6: all-ones row 3 survives a zero reload until the second commit
    loadRow(3, 32'hFFFF_FFFF, 0);
    applyStimulus({CMD_COMMIT, 28'h0});
    endBurst();
    repeat (2) @(negedge CLK);
    checkOutput("t6_se_ones",  512'(CONF_SE_ALL[3*SE_ROW +: SE_ROW]),    512'(24'hFF_FFFF));
    checkOutput("t6_alu_ones", 512'(CONF_ALU_ALL[3*ALU_ROW +: ALU_ROW]), 512'({ALU_ROW{1'b1}}));
    loadRow(3, 32'h0, 0);
    endBurst();
    @(negedge CLK);
    checkOutput("t6_se_hold",  512'(CONF_SE_ALL[3*SE_ROW +: SE_ROW]), 512'(24'hFF_FFFF));
    applyStimulus({CMD_COMMIT, 28'h0});
    endBurst();
    repeat (2) @(negedge CLK);
    checkOutput("t6_se_zero",  512'(CONF_SE_ALL[3*SE_ROW +: SE_ROW]), 512'(0));

    // 5: reset in the middle of a row 1 load, then a clean reload
    applyStimulus(load_hdr(1));
    for (int i = 0; i < 3; i++) applyStimulus(32'hAAAA_0000 + WORD_W'(i));
    endBurst();
    #2 RST = 1'b1;
    @(negedge CLK);
    checkOutput("t5_alu",   512'(CONF_ALU_ALL),   512'(0));
    checkOutput("t5_sel_a", 512'(CONF_SEL_A_ALL), 512'(0));
    checkOutput("t5_se",    512'(CONF_SE_ALL),    512'(0));
    checkOutput("t5_err",   512'(ERR),            512'(1'b0));
    checkOutput("t5_busy",  512'(BUSY),           512'(1'b0));
    #2 RST = 1'b0;
    @(negedge CLK);
    checkOutput("t5_ready", 512'(IN_READY), 512'(1'b1));
    loadRow(1, 32'h0000_0015, 1);
    applyStimulus({CMD_COMMIT, 28'h0});
    endBurst();
    repeat (2) @(negedge CLK);
    checkOutput("t5_alu_r1c0", 512'(CONF_ALU_ALL[1*ALU_ROW +: ALU_W]), 512'(5'h15));
    checkOutput("t5_alu_r2",   512'(CONF_ALU_ALL[2*ALU_ROW +: ALU_ROW]), 512'(0));

    repeat (2) @(negedge CLK);
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
